debounce_sync: RTL and testbench
================================

# debounce_sync

Upstream conditioning stage for the `d` input of the `d_ff` edge-triggered flip-flop. Takes an asynchronous, bouncy single-bit signal such as a push-button or switch and passes it through a synchronizer chain. It then qualifies each level change with a stability counter and presents a clean, glitch-free level on `q` for the downstream flip-flop. It also emits one-cycle rise/fall strobes and a saturating count of rejected glitches for debug.

## Interface
- `SYNC_STAGES`, default 2: synchronizer flops ahead of the qualifier; legal range ≥ 2.
- `STABLE_CYCLES`, default 4: consecutive synchronized samples required to accept a new level; legal range ≥ 1.
- `CNT_W`, default `$clog2(STABLE_CYCLES+1)`: stability counter width; derived, do not override.
- `clk`  in  1: single clock; all state updates on rising edge.
- `rst`  in  1: synchronous, active-high reset.
- `d_in`  in  1: raw asynchronous input; no timing relation to `clk`.
- `q`  out  1: debounced level; registered; feeds `d_ff.d`.
- `rise`  out  1: one-cycle strobe, high in the cycle `q` goes 0→1.
- `fall`  out  1: one-cycle strobe, high in the cycle `q` goes 1→0.
- `glitch_cnt`  out  8: rejected-transition counter; saturates at 255.

## Operation
- **Synchronizer.** `s[0] <= d_in`, `s[i] <= s[i-1]`. The qualifier uses only `s[SYNC_STAGES-1]`, called `ss` below.
- **FSM states.** LOW, RISING, HIGH, FALLING. `q` = 1 in HIGH and FALLING, 0 in LOW and RISING.
- **LOW**
  - If `ss` = 1 and `STABLE_CYCLES` = 1: go to HIGH and pulse `rise`.
  - Else if `ss` = 1: go to RISING with `cnt` = 1.
  - Else: stay in LOW.
- **RISING**
  - If `ss` = 0: go to LOW, `cnt` = 0, and increment `glitch_cnt`.
  - Else if `cnt+1` == `STABLE_CYCLES`: go to HIGH, `cnt` = 0, pulse `rise`.
  - Else: `cnt` = `cnt+1`.
- **HIGH, FALLING.** Mirror images of LOW and RISING with polarity swapped; `fall` replaces `rise`.
- **Strobes.** `rise` and `fall` are registered. They are never high together and never high for two consecutive cycles.
- **`glitch_cnt`.** Unsigned, increments by 1 per aborted RISING/FALLING episode, holds at 255.
- **No enable.** The block runs every cycle.

## Timing
- **Reset values** (on the first rising edge with `rst` = 1):
  - all `s[i]` = 0, state = LOW, `cnt` = 0
  - `q` = 0, `rise` = 0, `fall` = 0, `glitch_cnt` = 0
- **Reset priority.** `rst` overrides all other activity. Reset mid-RISING or mid-FALLING discards the episode and does not count it as a glitch.
- **Level latency.** Number the first edge that captures a new stable `d_in` level into `s[0]` as edge 1. `q` and its strobe change on edge `SYNC_STAGES + STABLE_CYCLES`, which is edge 6 at defaults.
- **Glitch rejection.** Any excursion of `ss` lasting fewer than `STABLE_CYCLES` samples produces no change on `q` and increments `glitch_cnt` by exactly 1.
- **Restart after abort.** An abort and an immediate re-toggle of `ss` in the next cycle restart counting from 1 (LOW→RISING, `cnt` = 1).
- **Metastability.** Only `s[0]` may go metastable; no logic samples `s[0]` directly.

## Structure
- **Shared include `debounce_defs.vh`:**
  - 2-bit state localparams: LOW = 2'd0, RISING = 2'd1, HIGH = 2'd2, FALLING = 2'd3
  - `GLITCH_W` = 8
- **Sub-module `sync_chain`**, parameterized by `SYNC_STAGES`: `clk`, `rst`, `d_in`, `d_sync`. The bench and other stages can reuse it for any asynchronous input.
- **Top level.** Instances of `debounce_sync` and `d_ff` connected in series: `debounce_sync.q` → `d_ff.d`.

## Test plan
- **Reset.** Hold `rst` = 1 for 2 cycles with `d_in` = 1 → `q` = 0, `rise` = 0, `glitch_cnt` = 0 throughout. After release, `q` rises on edge 6 with a single `rise` pulse.
- **Clean step.** Defaults, `d_in` 0→1 held 20 cycles, then 1→0:
  - `q` rises on edge 6 after the capture edge, then falls 6 edges after the fall is captured.
  - Exactly one `rise` pulse and one `fall` pulse.
- **Bounce.** `d_in` pattern 1,0,1,1,0,1,1,1,1 (one value per cycle, then held 1) → `q` stays 0 through the bounces. `q` goes high on the fourth consecutive `ss` = 1 sample. `glitch_cnt` = 2.
- **Saturation.** 300 pulses of 2-cycle width with `STABLE_CYCLES` = 4 → `q` never changes, `glitch_cnt` = 255.
- **`STABLE_CYCLES` = 1, `SYNC_STAGES` = 3.** A single-cycle `d_in` pulse:
  - `q` high for exactly 1 cycle, 3 edges after capture.
  - `rise` and `fall` on consecutive cycles.
  - No glitch counted.
- **Reset mid-RISING.** Assert `rst` in cycle 3 of a RISING episode → state = LOW, `q` = 0, `glitch_cnt` unchanged. Counting restarts from the first post-reset capture.

Source files
------------

// File: rtl/debounce_sync_pkg.sv
// Shared definitions for the debounce_sync conditioning stage: qualifier
// state encoding, glitch counter width and a saturating increment helper.
package debounce_sync_pkg;

    // Qualifier states; q is high in ST_HIGH and ST_FALLING.
    typedef enum logic [1:0] {
        ST_LOW     = 2'd0,
        ST_RISING  = 2'd1,
        ST_HIGH    = 2'd2,
        ST_FALLING = 2'd3
    } state_t;

    localparam int GLITCH_W = 8;

    // Increment by one, holding at all-ones.
    function automatic logic [GLITCH_W-1:0] glitch_sat_inc(input logic [GLITCH_W-1:0] v);
        return (v == '1) ? v : v + GLITCH_W'(1);
    endfunction

endpackage

// File: rtl/debounce_sync_sync_chain.sv
// Multi-flop synchronizer for a single asynchronous bit. Reusable for any
// input with no timing relation to clk.
module sync_chain #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic d_in,
    output logic d_sync
);

    logic [SYNC_STAGES-1:0] r_sync;

    // Shift the raw input through the chain; only the last flop is consumed.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments give every flop the pre-edge value of
        // its neighbour, which is what makes this a chain rather than a wire.
        if (rst) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], d_in};
        end
    end

    // NOTE: r_sync[0] may go metastable; nothing but the next flop reads it.
    assign d_sync = r_sync[SYNC_STAGES-1];

endmodule

// File: rtl/debounce_sync.sv
// Debouncer for a bouncy asynchronous input (button/switch). Synchronizes
// d_in, accepts a new level only after STABLE_CYCLES consecutive equal
// samples, and drives a clean registered level on q for the downstream d_ff.
// Also provides one-cycle rise/fall strobes and a saturating glitch count.
module debounce_sync
    import debounce_sync_pkg::*;
#(
    parameter int SYNC_STAGES   = 2,
    parameter int STABLE_CYCLES = 4,
    parameter int CNT_W         = $clog2(STABLE_CYCLES + 1)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                d_in,
    output logic                q,
    output logic                rise,
    output logic                fall,
    output logic [GLITCH_W-1:0] glitch_cnt
);

    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(STABLE_CYCLES);

    logic                w_ss;
    state_t              r_state;
    state_t              w_state_nxt;
    logic [CNT_W-1:0]    r_cnt;
    logic [CNT_W-1:0]    w_cnt_nxt;
    logic [CNT_W-1:0]    w_cnt_inc;
    logic                w_abort;
    logic                w_q_nxt;
    logic                w_rise_nxt;
    logic                w_fall_nxt;
    logic                r_q;
    logic                r_rise;
    logic                r_fall;
    logic [GLITCH_W-1:0] r_glitch;

    sync_chain #(
        .SYNC_STAGES(SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .rst   (rst),
        .d_in  (d_in),
        .d_sync(w_ss)
    );

    // cnt never exceeds STABLE_CYCLES-1, so the increment cannot wrap.
    assign w_cnt_inc = r_cnt + CNT_ONE;

    // State register: qualifier state and stability counter.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_LOW;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Next-state logic: count agreeing samples, abort on any disagreement.
    always_comb begin
        // NOTE: defaults first so every path assigns every output; no latches.
        w_state_nxt = r_state;
        w_cnt_nxt   = '0;
        w_abort     = 1'b0;
        case (r_state)
            ST_LOW: begin
                if (w_ss) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = ST_HIGH;
                    end else begin
                        w_state_nxt = ST_RISING;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_RISING: begin
                if (!w_ss) begin
                    w_state_nxt = ST_LOW;
                    w_abort     = 1'b1;
                end else if (w_cnt_inc == CNT_TARGET) begin
                    w_state_nxt = ST_HIGH;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            ST_HIGH: begin
                if (!w_ss) begin
                    if (STABLE_CYCLES == 1) begin
                        w_state_nxt = ST_LOW;
                    end else begin
                        w_state_nxt = ST_FALLING;
                        w_cnt_nxt   = CNT_ONE;
                    end
                end
            end
            ST_FALLING: begin
                if (w_ss) begin
                    w_state_nxt = ST_HIGH;
                    w_abort     = 1'b1;
                end else if (w_cnt_inc == CNT_TARGET) begin
                    w_state_nxt = ST_LOW;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                end
            end
            default: begin
                w_state_nxt = ST_LOW;
            end
        endcase
    end

    // Output decode: level from the next state, strobes from its change.
    always_comb begin
        w_q_nxt    = (w_state_nxt == ST_HIGH) || (w_state_nxt == ST_FALLING);
        w_rise_nxt = w_q_nxt & ~r_q;
        w_fall_nxt = ~w_q_nxt & r_q;
    end

    // Output registers: q and strobes are flops so q never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_q      <= 1'b0;
            r_rise   <= 1'b0;
            r_fall   <= 1'b0;
            r_glitch <= '0;
        end else begin
            r_q    <= w_q_nxt;
            r_rise <= w_rise_nxt;
            r_fall <= w_fall_nxt;
            if (w_abort) begin
                r_glitch <= glitch_sat_inc(r_glitch);
            end
        end
    end

    assign q          = r_q;
    assign rise       = r_rise;
    assign fall       = r_fall;
    assign glitch_cnt = r_glitch;

endmodule

// File: tb/tb_debounce_sync.sv
// Bench for debounce_sync: one instance at defaults (2 sync, 4 stable) and
// one at 3 sync / 1 stable, both checked every cycle against a run-length
// reference model, plus hand-derived vectors for the key timing cases.
module tb_debounce_sync;

    logic       clk;
    logic       rst;
    logic       d_a;
    logic       d_b;
    logic       q_a, rise_a, fall_a;
    logic       q_b, rise_b, fall_b;
    logic [7:0] glitch_a, glitch_b;

    int n_checks = 0;
    int n_errors = 0;

    debounce_sync dut_a (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_a),
        .q         (q_a),
        .rise      (rise_a),
        .fall      (fall_a),
        .glitch_cnt(glitch_a)
    );

    debounce_sync #(
        .SYNC_STAGES  (3),
        .STABLE_CYCLES(1)
    ) dut_b (
        .clk       (clk),
        .rst       (rst),
        .d_in      (d_b),
        .q         (q_b),
        .rise      (rise_b),
        .fall      (fall_b),
        .glitch_cnt(glitch_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: q flips once STABLE samples in a row disagree with it;
    // a disagreeing run that ends early is one glitch.
    typedef struct {
        bit q;
        int run;
        int glitch;
        bit rise;
        bit fall;
    } model_t;

    model_t ma, mb;
    bit     pipe_a[$];
    bit     pipe_b[$];

    function automatic model_t mstep(model_t m, bit ss, int stable);
        model_t n = m;
        n.rise = 1'b0;
        n.fall = 1'b0;
        if (ss != n.q) begin
            n.run++;
            if (n.run == stable) begin
                n.q    = ss;
                n.rise = ss;
                n.fall = !ss;
                n.run  = 0;
            end
        end else begin
            if (n.run > 0 && n.glitch < 255) n.glitch++;
            n.run = 0;
        end
        return n;
    endfunction

    task automatic model_reset();
        ma = '{q: 1'b0, run: 0, glitch: 0, rise: 1'b0, fall: 1'b0};
        mb = ma;
        pipe_a.delete();
        pipe_b.delete();
        repeat (2) pipe_a.push_back(1'b0);
        repeat (3) pipe_b.push_back(1'b0);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, update model at posedge, compare at negedge.
    task automatic step(input bit r, input bit da, input bit db);
        bit ss;
        rst = r;
        d_a = da;
        d_b = db;
        @(posedge clk);
        if (r) begin
            model_reset();
        end else begin
            ss = pipe_a.pop_front();
            pipe_a.push_back(da);
            ma = mstep(ma, ss, 4);
            ss = pipe_b.pop_front();
            pipe_b.push_back(db);
            mb = mstep(mb, ss, 1);
        end
        @(negedge clk);
        check("a_q", q_a, ma.q);
        check("a_rise", rise_a, ma.rise);
        check("a_fall", fall_a, ma.fall);
        check("a_glitch", glitch_a, ma.glitch);
        check("b_q", q_b, mb.q);
        check("b_rise", rise_b, mb.rise);
        check("b_fall", fall_b, mb.fall);
        check("b_glitch", glitch_b, mb.glitch);
        if (rise_a && fall_a) check("a_strobe_excl", 1, 0);
        if (rise_b && fall_b) check("b_strobe_excl", 1, 0);
    endtask

    typedef struct {
        bit rst;
        bit d;
        bit q;
        bit rise;
        bit fall;
        int glitch;
    } vec_t;

    vec_t tbl[16];

    bit   bseq[9] = '{1, 0, 1, 1, 0, 1, 1, 1, 1};
    bit   qh[12];
    bit   rh[12];
    bit   fh[12];
    bit   q_seen;

    initial begin
        // Reset with d=1, release, clean rise on edge 6, clean fall 6 edges later.
        tbl[0] = '{1, 1, 0, 0, 0, 0};
        tbl[1] = '{1, 1, 0, 0, 0, 0};
        for (int i = 2; i <= 6; i++) tbl[i] = '{0, 1, 0, 0, 0, 0};
        tbl[7] = '{0, 1, 1, 1, 0, 0};
        tbl[8] = '{0, 1, 1, 0, 0, 0};
        for (int i = 9; i <= 13; i++) tbl[i] = '{0, 0, 1, 0, 0, 0};
        tbl[14] = '{0, 0, 0, 0, 1, 0};
        tbl[15] = '{0, 0, 0, 0, 0, 0};

        rst = 1'b1;
        d_a = 1'b0;
        d_b = 1'b0;
        model_reset();
        @(negedge clk);

        for (int i = 0; i < 16; i++) begin
            step(tbl[i].rst, tbl[i].d, 1'b0);
            check($sformatf("tbl%0d_q", i), q_a, tbl[i].q);
            check($sformatf("tbl%0d_rise", i), rise_a, tbl[i].rise);
            check($sformatf("tbl%0d_fall", i), fall_a, tbl[i].fall);
            check($sformatf("tbl%0d_glitch", i), glitch_a, tbl[i].glitch);
        end

        // Bounce: two aborted episodes, q rises on edge 11 (9th ss sample).
        for (int i = 0; i < 12; i++) begin
            step(1'b0, (i < 9) ? bseq[i] : 1'b1, 1'b0);
            qh[i] = q_a;
            rh[i] = rise_a;
        end
        q_seen = 1'b0;
        for (int i = 0; i < 10; i++) q_seen |= qh[i];
        check("bounce_q_low", q_seen, 0);
        check("bounce_q_edge11", qh[10], 1);
        check("bounce_rise_edge11", rh[10], 1);
        check("bounce_glitch", glitch_a, 2);
        repeat (10) step(1'b0, 1'b0, 1'b0);
        check("bounce_q_back_low", q_a, 0);

        // Saturation: 300 two-cycle pulses never qualify.
        q_seen = 1'b0;
        for (int p = 0; p < 300; p++) begin
            step(1'b0, 1'b1, 1'b0);
            q_seen |= q_a;
            step(1'b0, 1'b1, 1'b0);
            q_seen |= q_a;
            repeat (3) begin
                step(1'b0, 1'b0, 1'b0);
                q_seen |= q_a;
            end
        end
        check("sat_q_never_high", q_seen, 0);
        check("sat_glitch", glitch_a, 255);

        // STABLE_CYCLES=1, SYNC_STAGES=3: single-cycle pulse.
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, (i == 0));
            qh[i] = q_b;
            rh[i] = rise_b;
            fh[i] = fall_b;
        end
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b_pulse_q%0d", i + 1), qh[i], (i == 3));
            check($sformatf("b_pulse_rise%0d", i + 1), rh[i], (i == 3));
            check($sformatf("b_pulse_fall%0d", i + 1), fh[i], (i == 4));
        end
        check("b_pulse_glitch", glitch_b, 0);

        // Reset in the third cycle of RISING: no glitch, counting restarts.
        step(1'b1, 1'b0, 1'b0);
        repeat (4) step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0);
        check("midrise_q", q_a, 0);
        check("midrise_glitch", glitch_a, 0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b1, 1'b0);
            qh[i] = q_a;
            rh[i] = rise_a;
        end
        check("midrise_q_edge5", qh[4], 0);
        check("midrise_q_edge6", qh[5], 1);
        check("midrise_rise_edge6", rh[5], 1);
        check("midrise_glitch_after", glitch_a, 0);

        // Random bouncing on both inputs with occasional resets.
        begin
            int  cyc = 0;
            bit  va, vb;
            int  la, lb;
            va = 1'b0;
            vb = 1'b0;
            la = 0;
            lb = 0;
            while (cyc < 4000) begin
                if (la == 0) begin
                    va = $urandom_range(0, 1);
                    la = $urandom_range(1, 8);
                end
                if (lb == 0) begin
                    vb = $urandom_range(0, 1);
                    lb = $urandom_range(1, 3);
                end
                step(($urandom_range(0, 199) == 0), va, vb);
                la--;
                lb--;
                cyc++;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
